// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle shared by the requesters, the FIFO write side and the
// round-robin arbiter. The arbiter uses the slave view; the requesters and
// FIFO (or a bench standing in for them) use the master view.
interface fifo_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic               wfull;
   logic               winc;
   logic [DW-1:0]      wdata;
   logic [NREQ-1:0]    ack;
   logic               grant_valid;
   logic [IDW-1:0]     grant_id;
   logic [7:0]         beat_cnt;

   modport slave (
      input  req, req_data, req_last, wfull,
      output winc, wdata, ack, grant_valid, grant_id, beat_cnt
   );

   modport master (
      output req, req_data, req_last, wfull,
      input  winc, wdata, ack, grant_valid, grant_id, beat_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sitting in front of the async FIFO write
// pointer. A winner keeps the port for up to MAX_BURST beats or until its
// last beat; every write is gated by the FIFO full flag so the FIFO can
// never be overrun. One idle cycle separates consecutive grants.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input logic              clk,
   input logic              rst,
   fifo_wr_arbiter_if.slave arb
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = IDW + 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [IDW-1:0] lastPtr_q, lastPtr_d;
   logic [IDW-1:0] grantId_q, grantId_d;
   logic           grantValid_q, grantValid_d;
   logic [7:0]     beatCnt_q, beatCnt_d;

   logic [CW-1:0]   candIdx;
   logic            winnerFound;
   logic [IDW-1:0]  winnerId;
   logic            inGrant;
   logic            accept;
   logic            withdraw;
   logic            burstDone;
   logic            grantEnd;
   logic [NREQ-1:0] ackVec;

   // Search upward from the requester after the last winner, wrapping modulo
   // NREQ with a subtract so non-power-of-2 requester counts stay correct.
   always_comb begin
      candIdx     = '0;
      winnerFound = 1'b0;
      winnerId    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         candIdx = CW'(lastPtr_q) + CW'(k);
         if (candIdx >= CW'(NREQ)) begin
            candIdx = candIdx - CW'(NREQ);
         end
         if (!winnerFound && arb.req[candIdx[IDW-1:0]]) begin
            winnerFound = 1'b1;
            winnerId    = candIdx[IDW-1:0];
         end
      end
   end

   // Beat handshake for the held grant; purely combinational so the FIFO
   // sees winc in the same cycle the requester sees its ack.
   always_comb begin
      inGrant   = (state_q == GRANT);
      accept    = inGrant && arb.req[grantId_q] && !arb.wfull;
      withdraw  = inGrant && !arb.req[grantId_q];
      burstDone = accept && (arb.req_last[grantId_q] ||
                             (beatCnt_q + 8'd1 == 8'(MAX_BURST)));
      grantEnd  = burstDone || withdraw;
      ackVec    = '0;
      for (int i = 0; i < NREQ; i++) begin
         ackVec[i] = accept && (grantId_q == IDW'(i));
      end
   end

   assign arb.winc        = accept;
   assign arb.wdata       = arb.req_data[int'(grantId_q)*DW +: DW];
   assign arb.ack         = ackVec;
   assign arb.grant_valid = grantValid_q;
   assign arb.grant_id    = grantId_q;
   assign arb.beat_cnt    = beatCnt_q;

   // Grant FSM: IDLE latches the round-robin winner, GRANT counts accepted
   // beats and hands the port back on last beat, burst limit or withdrawal.
   // A full FIFO simply stalls the grant without counting or timing out.
   always_comb begin
      state_d      = state_q;
      lastPtr_d    = lastPtr_q;
      grantId_d    = grantId_q;
      grantValid_d = grantValid_q;
      beatCnt_d    = beatCnt_q;
      case (state_q)
         IDLE: begin
            if (winnerFound) begin
               state_d      = GRANT;
               grantId_d    = winnerId;
               grantValid_d = 1'b1;
               beatCnt_d    = 8'd0;
            end
         end
         GRANT: begin
            if (grantEnd) begin
               state_d      = IDLE;
               grantValid_d = 1'b0;
               lastPtr_d    = grantId_q;
               beatCnt_d    = 8'd0;
            end else if (accept) begin
               beatCnt_d = beatCnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset leaves requester 0 with top priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lastPtr_q    <= IDW'(NREQ - 1);
         grantId_q    <= '0;
         grantValid_q <= 1'b0;
         beatCnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         lastPtr_q    <= lastPtr_d;
         grantId_q    <= grantId_d;
         grantValid_q <= grantValid_d;
         beatCnt_q    <= beatCnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for the round-robin FIFO write arbiter. Directed
// requester traffic is loaded with hand-computed expected writes and grants;
// negedge monitors pop and compare whenever the DUT writes or a grant closes.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   typedef struct {
      int id;
      int data;
   } writeT;

   typedef struct {
      int id;
      int beats;
      int gap;
   } grantT;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int testsRun = 0;
   int failCnt  = 0;

   writeT expWrites[$];
   grantT expGrants[$];
   int    expGrant3[$];
   int    expWrite3[$];

   int remaining[NREQ];
   int sent[NREQ];
   int base[NREQ];
   bit lastFlag[NREQ];

   bit prevValid = 1'b0;
   int idleCnt   = 0;
   int curId     = 0;
   int curBeats  = 0;
   int curGap    = 0;
   bit prevValid3 = 1'b0;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
   fifo_wr_arbiter_if #(.NREQ(3), .DW(DW)) bus3 ();

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk (clock),
      .rst (reset),
      .arb (bus)
   );

   fifo_wr_arbiter #(.NREQ(3), .DW(DW), .MAX_BURST(MAX_BURST)) dut3 (
      .clk (clock),
      .rst (reset),
      .arb (bus3)
   );

   always #5 clock = ~clock;

   // One comparison: counts it and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic driveBus();
      for (int i = 0; i < NREQ; i++) begin
         bus.req[i]                = (remaining[i] > 0);
         bus.req_data[i*DW +: DW]  = 8'(base[i] + sent[i]);
         bus.req_last[i]           = lastFlag[i] && (remaining[i] == 1);
      end
   endtask

   // Load requester id with a burst of beats; data counts up from b.
   task automatic applyStimulus(input int id, input int beats, input int b,
                                input bit withLast);
      remaining[id] = beats;
      sent[id]      = 0;
      base[id]      = b;
      lastFlag[id]  = withLast;
      driveBus();
   endtask

   task automatic pushWrites(input int id, input int firstData, input int n);
      for (int k = 0; k < n; k++) begin
         expWrites.push_back('{id: id, data: (firstData + k) & 8'hff});
      end
   endtask

   task automatic pushGrant(input int id, input int beats, input int gap);
      expGrants.push_back('{id: id, beats: beats, gap: gap});
   endtask

   // Advance one cycle; requesters consume beats acked in the ending cycle.
   task automatic tick();
      logic [NREQ-1:0] ackSeen;
      @(negedge clock);
      ackSeen = bus.ack;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (ackSeen[i] && remaining[i] > 0) begin
            sent[i]++;
            remaining[i]--;
         end
      end
      driveBus();
   endtask

   task automatic toDrive();
      @(posedge clock);
      #1;
   endtask

   task automatic applyReset();
      reset     = 1'b1;
      bus.wfull = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         sent[i]      = 0;
         lastFlag[i]  = 1'b0;
      end
      driveBus();
      tick();
      tick();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rstGrantValid", 32'(bus.grant_valid), 32'd0);
      checkOutput("rstGrantId", 32'(bus.grant_id), 32'd0);
      checkOutput("rstBeatCnt", 32'(bus.beat_cnt), 32'd0);
      checkOutput("rstWinc", 32'(bus.winc), 32'd0);
      checkOutput("rstAck", 32'(bus.ack), 32'd0);
      toDrive();
   endtask

   // Run until traffic drains and every expectation is consumed, bounded.
   task automatic runUntilIdle(input int maxCycles, input string tag);
      int  n;
      bit  busy;
      n = 0;
      forever begin
         busy = (expWrites.size() != 0) || (expGrants.size() != 0) || bus.grant_valid;
         for (int i = 0; i < NREQ; i++) begin
            if (remaining[i] > 0) busy = 1'b1;
         end
         if (!busy) break;
         if (n >= maxCycles) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL timeout_%s: got %0d cycles, expected drain within %0d",
                     tag, n, maxCycles);
            break;
         end
         tick();
         n++;
      end
   endtask

   // Write scoreboard and grant tracker for the NREQ=4 instance.
   always @(negedge clock) begin
      writeT w;
      grantT g;
      if (bus.wfull) begin
         checkOutput("wincWhileFull", 32'(bus.winc), 32'd0);
      end
      if (bus.winc) begin
         if (expWrites.size() == 0) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL unexpectedWrite: got data 0x%0h, expected no write", bus.wdata);
         end else begin
            w = expWrites.pop_front();
            checkOutput("wdata", 32'(bus.wdata), 32'(w.data));
            checkOutput("ack", 32'(bus.ack), 32'(1) << w.id);
         end
      end else begin
         checkOutput("ackNoWrite", 32'(bus.ack), 32'd0);
      end

      if (bus.grant_valid && !prevValid) begin
         curId    = int'(bus.grant_id);
         curBeats = 0;
         curGap   = idleCnt;
      end
      if (bus.grant_valid && bus.winc) curBeats++;
      if (!bus.grant_valid && prevValid) begin
         if (expGrants.size() == 0) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL unexpectedGrant: got id %0d, expected none", curId);
         end else begin
            g = expGrants.pop_front();
            checkOutput("grantId", 32'(curId), 32'(g.id));
            checkOutput("grantBeats", 32'(curBeats), 32'(g.beats));
            if (g.gap >= 0) checkOutput("idleGap", 32'(curGap), 32'(g.gap));
         end
      end
      if (bus.grant_valid) idleCnt = 0;
      else idleCnt++;
      prevValid = bus.grant_valid;
   end

   // Grant-order and write-data checker for the NREQ=3 instance.
   always @(negedge clock) begin
      int e;
      if (bus3.grant_valid && !prevValid3) begin
         if (expGrant3.size() == 0) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL unexpectedGrant3: got id %0d, expected none", bus3.grant_id);
         end else begin
            e = expGrant3.pop_front();
            checkOutput("grantId3", 32'(bus3.grant_id), 32'(e));
         end
      end
      if (bus3.winc) begin
         if (expWrite3.size() == 0) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL unexpectedWrite3: got 0x%0h, expected no write", bus3.wdata);
         end else begin
            e = expWrite3.pop_front();
            checkOutput("wdata3", 32'(bus3.wdata), 32'(e));
         end
      end
      prevValid3 = bus3.grant_valid;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic [2:0] ack3;
      bus.wfull     = 1'b0;
      bus3.wfull    = 1'b0;
      bus3.req      = 3'b000;
      bus3.req_last = 3'b111;
      bus3.req_data = {8'hC2, 8'hB1, 8'hA0};
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         sent[i]      = 0;
         base[i]      = 0;
         lastFlag[i]  = 1'b0;
      end
      driveBus();

      // Single requester 2, three beats with last on the third.
      applyReset();
      applyStimulus(2, 3, 8'h20, 1'b1);
      pushWrites(2, 8'h20, 3);
      pushGrant(2, 3, -1);
      @(negedge clock);
      checkOutput("bubbleWinc", 32'(bus.winc), 32'd0);
      checkOutput("bubbleValid", 32'(bus.grant_valid), 32'd0);
      toDrive();
      runUntilIdle(40, "single");
      @(negedge clock);
      checkOutput("beatCntAfterLast", 32'(bus.beat_cnt), 32'd0);
      checkOutput("grantIdRetained", 32'(bus.grant_id), 32'd2);
      toDrive();

      // All four requesting with no last: 0,1,2,3,0 with 4 beats each.
      applyReset();
      applyStimulus(0, 8, 8'h40, 1'b0);
      applyStimulus(1, 4, 8'h50, 1'b0);
      applyStimulus(2, 4, 8'h60, 1'b0);
      applyStimulus(3, 4, 8'h70, 1'b0);
      pushWrites(0, 8'h40, 4);
      pushWrites(1, 8'h50, 4);
      pushWrites(2, 8'h60, 4);
      pushWrites(3, 8'h70, 4);
      pushWrites(0, 8'h44, 4);
      pushGrant(0, 4, -1);
      pushGrant(1, 4, 1);
      pushGrant(2, 4, 1);
      pushGrant(3, 4, 1);
      pushGrant(0, 4, 1);
      runUntilIdle(100, "roundRobin");

      // Requester 1 stalled by a full FIFO for five cycles after two beats;
      // its fourth beat is both last and the burst limit.
      applyReset();
      applyStimulus(1, 4, 8'h10, 1'b1);
      pushWrites(1, 8'h10, 4);
      pushGrant(1, 4, -1);
      n = 0;
      while (sent[1] < 2 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("stallSetupBeats", 32'(sent[1]), 32'd2);
      bus.wfull = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         checkOutput("stallWinc", 32'(bus.winc), 32'd0);
         checkOutput("stallAck", 32'(bus.ack), 32'd0);
         checkOutput("stallBeatCnt", 32'(bus.beat_cnt), 32'd2);
         checkOutput("stallValid", 32'(bus.grant_valid), 32'd1);
         checkOutput("stallGrantId", 32'(bus.grant_id), 32'd1);
         toDrive();
      end
      bus.wfull = 1'b0;
      runUntilIdle(40, "stall");

      // Requester 3 withdraws after two beats (last pointer ends at 3),
      // then requesters 0 and 2 compete and 0 must win first.
      applyStimulus(3, 2, 8'h78, 1'b0);
      pushWrites(3, 8'h78, 2);
      pushGrant(3, 2, -1);
      runUntilIdle(40, "withdraw");
      @(negedge clock);
      checkOutput("withdrawBeatCnt", 32'(bus.beat_cnt), 32'd0);
      checkOutput("withdrawGrantId", 32'(bus.grant_id), 32'd3);
      toDrive();
      applyStimulus(2, 1, 8'h62, 1'b1);
      applyStimulus(0, 1, 8'h60, 1'b1);
      pushWrites(0, 8'h60, 1);
      pushWrites(2, 8'h62, 1);
      pushGrant(0, 1, -1);
      pushGrant(2, 1, 1);
      runUntilIdle(40, "afterWithdraw");

      // Reset lands on beat 2 of a grant to requester 1; that beat is
      // still written, then requesters 0 and 1 restart from priority 0.
      applyReset();
      applyStimulus(1, 4, 8'h30, 1'b1);
      pushWrites(1, 8'h30, 2);
      pushGrant(1, 2, -1);
      n = 0;
      while (sent[1] < 1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("rstSetupBeats", 32'(sent[1]), 32'd1);
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      remaining[1] = 0;
      driveBus();
      @(negedge clock);
      checkOutput("midRstValid", 32'(bus.grant_valid), 32'd0);
      checkOutput("midRstGrantId", 32'(bus.grant_id), 32'd0);
      checkOutput("midRstWinc", 32'(bus.winc), 32'd0);
      toDrive();
      applyStimulus(0, 1, 8'h50, 1'b1);
      applyStimulus(1, 1, 8'h51, 1'b1);
      pushWrites(0, 8'h50, 1);
      pushWrites(1, 8'h51, 1);
      pushGrant(0, 1, -1);
      pushGrant(1, 1, 1);
      runUntilIdle(40, "afterReset");

      // Three-requester instance: req 3'b101 from reset, 0 wins then 2.
      applyReset();
      expGrant3.push_back(0);
      expGrant3.push_back(2);
      expWrite3.push_back(8'hA0);
      expWrite3.push_back(8'hC2);
      bus3.req = 3'b101;
      n = 0;
      while ((bus3.req != 3'b000 || bus3.grant_valid || expGrant3.size() != 0) && n < 40) begin
         @(negedge clock);
         ack3 = bus3.ack;
         toDrive();
         bus3.req = bus3.req & ~ack3;
         n++;
      end
      if (n >= 40) begin
         testsRun++;
         failCnt++;
         $display("[TB] FAIL timeout_wrap3: got %0d cycles, expected drain within 40", n);
      end
      repeat (3) tick();

      checkOutput("leftoverWrites", 32'(expWrites.size()), 32'd0);
      checkOutput("leftoverGrants", 32'(expGrants.size()), 32'd0);
      checkOutput("leftoverGrants3", 32'(expGrant3.size()), 32'd0);
      checkOutput("leftoverWrites3", 32'(expWrite3.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO among NREQ same-clock requesters. A granted requester keeps the write port for a burst of up to MAX_BURST beats, or until its last beat. All FIFO writes are gated by the write-side full flag. The block sits in the write clock domain, directly in front of the FIFO's write pointer/increment logic.

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 8, data width per requester
MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
clk  input  1  write-domain clock
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request; bit i = requester i has a beat available
req_data  input  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW]
req_last  input  NREQ  per-requester flag: the current beat ends the burst
wfull  input  1  FIFO write-side full flag
winc  output  1  FIFO write increment (combinational)
wdata  output  DW  FIFO write data (combinational mux of the granted requester)
ack  output  NREQ  one-hot: the granted requester's beat is accepted this cycle
grant_valid  output  1  registered; a grant is held
grant_id  output  $clog2(NREQ)  registered; index of the granted requester
beat_cnt  output  8  registered; beats accepted in the current grant

Behaviour:
- Reset: all registered state is cleared on the rising clk edge when rst=1. rst overrides all other inputs.
  - State becomes IDLE.
  - grant_valid=0, grant_id=0, beat_cnt=0.
  - Last-granted pointer is set to NREQ-1, so requester 0 has highest priority after reset.
  - winc=0 and ack=0 while state is IDLE.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from (last+1) mod NREQ, wrapping around.
  - On the next edge: grant_id <= winner, grant_valid <= 1, beat_cnt <= 0, state <= GRANT.
  - No write occurs in IDLE. Arbitration latency is 1 cycle.
- GRANT, with g = grant_id:
  - Accept condition: accept = req[g] & ~wfull.
  - winc = accept. wdata = req_data[g]. ack = accept << g.
  - All other ack bits are 0. The ack and winc paths have no pipeline delay.
  - On an accept, beat_cnt increments.
- Leaving GRANT: the grant ends on the edge where any one of the following holds:
  - accept & req_last[g];
  - accept & (beat_cnt+1 == MAX_BURST);
  - req[g]==0, meaning the requester withdrew (no write occurs that cycle).
- On grant end:
  - state <= IDLE, grant_valid <= 0, last <= g, beat_cnt <= 0.
  - grant_id retains its value.
- Full flag: wfull=1 stalls the burst. The grant is held, no beat is counted, ack=0, and the grant does not time out.
  - winc must never be 1 while wfull=1. This protects the FIFO from overflow.
- Simultaneous last and MAX_BURST: a single grant end occurs.
- Requests arriving during GRANT: they are not evaluated until the next IDLE cycle.
- Back-to-back bursts: there is one IDLE bubble cycle between consecutive grants, including when the same requester wins again.
- Starvation bound: any continuously asserted requester is granted within NREQ-1 intervening grants.
- Reset during a burst: the same-edge abort goes to IDLE. A beat acked in the reset cycle is still written, since the FIFO sees winc combinationally. No further acks occur after that.
- Width rules:
  - beat_cnt saturates logically at MAX_BURST; it never exceeds MAX_BURST.
  - The pointer arithmetic is modulo NREQ, correct for non-power-of-2 NREQ.

Test Plan:
- Reset, then req=4'b0100 with 3 beats and req_last on beat 3:
  - idle bubble, then grant_id=2;
  - winc/ack[2] for 3 consecutive cycles; wdata matches beats 1..3;
  - back to IDLE; beat_cnt returns to 0.
- req=4'b1111 held, req_last=0, MAX_BURST=4:
  - grants in order 0,1,2,3,0;
  - each grant gives exactly 4 writes, followed by 1 idle cycle.
- Granted requester 1, wfull forced high for 5 cycles mid-burst:
  - winc=0 and ack=0 throughout;
  - beat_cnt frozen; grant held;
  - the burst resumes and completes when wfull drops.
- Requester 3 drops req after 2 beats:
  - grant ends with no write that cycle; beat_cnt=0;
  - the next arbitration starts from requester 0 (last=3).
- rst asserted during beat 2 of a grant to requester 1:
  - the following cycle has grant_valid=0, grant_id=0, winc=0;
  - next request set 4'b0011 grants requester 0 first.
- NREQ=3, req=3'b101, last=2:
  - requester 0 wins;
  - after its grant, requester 2 wins (wrap check).
